// File: rtl/mdu_if.sv
// Bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the request fields; the unit returns busy, stall and HI/LO.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B,
        input  busy, md_stall, HI, LO
    );

    modport slave (
        input  start, op, A, B,
        output busy, md_stall, HI, LO
    );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers for a MIPS-style pipeline.
// A request is accepted in IDLE.
// The unit then holds busy for a fixed number of cycles.
// The result is computed combinationally from the latched operands and
// written to HI/LO on the last RUN edge.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; mthi/mtlo write HI/LO directly here
//   RUN   | mult/div in flight; cnt counts remaining cycles down to 1
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    mdu_if.slave   bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         next_state;

    logic [CW-1:0]  cnt;
    logic           busy_q;
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;

    // Latched request: op_q[1] selects divide, op_q[0] selects unsigned.
    logic [1:0]     op_q;
    logic [31:0]    a_q;
    logic [31:0]    b_q;

    logic           load;
    logic           commit;
    logic           write_hi;
    logic           write_lo;

    logic [63:0]    mul_a;
    logic [63:0]    mul_b;
    logic [63:0]    product;
    logic           a_neg;
    logic           b_neg;
    logic [31:0]    div_ua;
    logic [31:0]    div_ub;
    logic [31:0]    div_ub_safe;
    logic [31:0]    div_uq;
    logic [31:0]    div_ur;
    logic [31:0]    quotient;
    logic [31:0]    remainder;
    logic           div_by_zero;
    logic [31:0]    res_hi;
    logic [31:0]    res_lo;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-edge control strobes.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        commit     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            load       = 1'b1;
                            next_state = RUN;
                        end
                        OP_MTHI: write_hi = 1'b1;
                        OP_MTLO: write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Requests arriving here are dropped; the hazard unit holds them off.
                if (cnt == CW'(1)) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Result datapath from the latched operands.
    // Division works on magnitudes so the most-negative dividend over -1
    // wraps to 0x80000000 with a zero remainder instead of overflowing.
    always_comb begin
        mul_a       = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
        mul_b       = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
        product     = mul_a * mul_b;

        a_neg       = ~op_q[0] & a_q[31];
        b_neg       = ~op_q[0] & b_q[31];
        div_ua      = a_neg ? (~a_q + 32'd1) : a_q;
        div_ub      = b_neg ? (~b_q + 32'd1) : b_q;
        div_by_zero = op_q[1] & (b_q == 32'd0);
        div_ub_safe = (div_ub == 32'd0) ? 32'd1 : div_ub;
        div_uq      = div_ua / div_ub_safe;
        div_ur      = div_ua % div_ub_safe;
        quotient    = (a_neg ^ b_neg) ? (~div_uq + 32'd1) : div_uq;
        remainder   = a_neg ? (~div_ur + 32'd1) : div_ur;

        if (op_q[1]) begin
            res_hi = remainder;
            res_lo = quotient;
        end else begin
            res_hi = product[63:32];
            res_lo = product[31:0];
        end
    end

    // Operand latch, cycle counter, busy flag and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= 2'b00;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            if (load) begin
                op_q   <= bus.op[1:0];
                a_q    <= bus.A;
                b_q    <= bus.B;
                cnt    <= bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                busy_q <= 1'b1;
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
                if (commit) begin
                    busy_q <= 1'b0;
                    if (!div_by_zero) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
            end
            if (write_hi) begin
                hi_q <= bus.A;
            end
            if (write_lo) begin
                lo_q <= bus.A;
            end
        end
    end

    // Stall is forced low while reset is held, even if start is high.
    assign bus.md_stall = reset & (busy_q | (bus.start & ~bus.op[2]));
    assign bus.busy     = busy_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for the multiply/divide unit.
// Inputs are driven 1 ns after the rising edge.
// Outputs are sampled on the falling edge.
module tb_mdu;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mdu_if bus ();

    mdu #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one rising edge; returns 1 ns after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count falling edges with busy high.
    // Also notes whether HI/LO moved while busy was high.
    task automatic wait_done(output int cycles, output bit held);
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0    = bus.HI;
        lo0    = bus.LO;
        cycles = 0;
        held   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            cycles++;
            if (bus.HI !== hi0 || bus.LO !== lo0) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.A     = 32'h1;
        bus.B     = 32'h1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
            errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", bus.HI, bus.LO);
        end
        checks++;
        if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.md_stall); end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_md_stall;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 3'b100;
        #1;
        checks++;
        if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL stall_mthi: got %b want 0", bus.md_stall); end
        bus.op = 3'b110;
        #1;
        checks++;
        if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL stall_reserved: got %b want 0", bus.md_stall); end
        bus.op = 3'b010;
        #1;
        checks++;
        if (bus.md_stall !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL stall_div_req: got stall=%b busy=%b want 1/0", bus.md_stall, bus.busy);
        end
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b want 0", bus.md_stall); end
    endtask

    task automatic test_mult;
        int cyc;
        bit held;
        issue(3'b000, 32'hFFFFFFFE, 32'd3);
        wait_done(cyc, held);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL mult_busy: got %0d cycles want 5", cyc); end
        checks++;
        if (!held) begin errors++; $display("FAIL mult_hold: HI/LO changed during RUN, got 1 want 0"); end
        checks++;
        if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFA) begin
            errors++; $display("FAIL mult_result: got %h/%h want ffffffff/fffffffa", bus.HI, bus.LO);
        end
    endtask

    task automatic test_multu;
        int cyc;
        bit held;
        issue(3'b001, 32'hFFFFFFFF, 32'd2);
        wait_done(cyc, held);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL multu_busy: got %0d cycles want 5", cyc); end
        checks++;
        if (bus.HI !== 32'h00000001 || bus.LO !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL multu_result: got %h/%h want 00000001/fffffffe", bus.HI, bus.LO);
        end
    endtask

    task automatic test_div;
        int cyc;
        bit held;
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc, held);
        checks++;
        if (cyc !== 10) begin errors++; $display("FAIL div_busy: got %0d cycles want 10", cyc); end
        checks++;
        if (!held) begin errors++; $display("FAIL div_hold: HI/LO changed during RUN, got 1 want 0"); end
        checks++;
        if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL div_neg_dividend: got %h/%h want ffffffff/fffffffd", bus.HI, bus.LO);
        end
        // 7 / -2 = -3 remainder 1
        issue(3'b010, 32'd7, 32'hFFFFFFFE);
        wait_done(cyc, held);
        checks++;
        if (bus.HI !== 32'h00000001 || bus.LO !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL div_neg_divisor: got %h/%h want 00000001/fffffffd", bus.HI, bus.LO);
        end
        // divu 0xFFFFFFF9 / 2 = 0x7FFFFFFC remainder 1
        issue(3'b011, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc, held);
        checks++;
        if (bus.HI !== 32'h00000001 || bus.LO !== 32'h7FFFFFFC) begin
            errors++; $display("FAIL divu_result: got %h/%h want 00000001/7ffffffc", bus.HI, bus.LO);
        end
    endtask

    task automatic test_div_overflow;
        int cyc;
        bit held;
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc, held);
        checks++;
        if (cyc !== 10) begin errors++; $display("FAIL div_ovf_busy: got %0d cycles want 10", cyc); end
        checks++;
        if (bus.HI !== 32'h0 || bus.LO !== 32'h80000000) begin
            errors++; $display("FAIL div_ovf_result: got %h/%h want 00000000/80000000", bus.HI, bus.LO);
        end
    endtask

    task automatic test_mthi_mtlo;
        issue(3'b100, 32'h11, 32'h0);
        checks++;
        if (bus.HI !== 32'h11 || bus.LO !== 32'h80000000 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mthi: got %h/%h busy=%b want 00000011/80000000 busy=0", bus.HI, bus.LO, bus.busy);
        end
        issue(3'b101, 32'h22, 32'h0);
        checks++;
        if (bus.HI !== 32'h11 || bus.LO !== 32'h22 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mtlo: got %h/%h busy=%b want 00000011/00000022 busy=0", bus.HI, bus.LO, bus.busy);
        end
        issue(3'b110, 32'h99, 32'h99);
        @(negedge clk);
        checks++;
        if (bus.HI !== 32'h11 || bus.LO !== 32'h22 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reserved_op: got %h/%h busy=%b want 00000011/00000022 busy=0", bus.HI, bus.LO, bus.busy);
        end
    endtask

    task automatic test_div_by_zero;
        int cyc;
        bit held;
        issue(3'b011, 32'd5, 32'd0);
        wait_done(cyc, held);
        checks++;
        if (cyc !== 10) begin errors++; $display("FAIL divzero_busy: got %0d cycles want 10", cyc); end
        checks++;
        if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
            errors++; $display("FAIL divzero_retain: got %h/%h want 00000011/00000022", bus.HI, bus.LO);
        end
    endtask

    task automatic test_ignore_in_run;
        int cyc;
        bit held;
        bit stall_seen;
        issue(3'b011, 32'd100, 32'd7);
        fork
            wait_done(cyc, held);
            begin
                bus.start = 1'b1;
                bus.op    = 3'b101;
                bus.A     = 32'h55;
                @(posedge clk);
                #1;
                bus.op = 3'b000;
                bus.A  = 32'd3;
                bus.B  = 32'd4;
                stall_seen = bus.md_stall;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                bus.A     = 32'hDEAD;
                bus.B     = 32'h1;
            end
        join
        checks++;
        if (stall_seen !== 1'b1) begin errors++; $display("FAIL run_stall: got %b want 1", stall_seen); end
        checks++;
        if (cyc !== 10) begin errors++; $display("FAIL ignore_busy: got %0d cycles want 10", cyc); end
        checks++;
        if (!held) begin errors++; $display("FAIL ignore_hold: HI/LO changed during RUN, got 1 want 0"); end
        checks++;
        if (bus.HI !== 32'd2 || bus.LO !== 32'd14) begin
            errors++; $display("FAIL ignore_result: got %h/%h want 00000002/0000000e", bus.HI, bus.LO);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        bit held;
        issue(3'b000, 32'd5, 32'd6);
        repeat (2) @(negedge clk);
        #2;
        reset     = 1'b0;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
            errors++; $display("FAIL midrun_reset: got busy=%b %h/%h want 0 00000000/00000000", bus.busy, bus.HI, bus.LO);
        end
        checks++;
        if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL midrun_reset_stall: got %b want 0", bus.md_stall); end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.LO !== 32'h0) begin
            errors++; $display("FAIL midrun_discard: got busy=%b LO=%h want 0 00000000", bus.busy, bus.LO);
        end
        issue(3'b000, 32'h00012345, 32'h00010000);
        wait_done(cyc, held);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL post_reset_busy: got %0d cycles want 5", cyc); end
        checks++;
        if (bus.HI !== 32'h00000001 || bus.LO !== 32'h23450000) begin
            errors++; $display("FAIL post_reset_result: got %h/%h want 00000001/23450000", bus.HI, bus.LO);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_md_stall();
        test_mult();
        test_multu();
        test_div();
        test_div_overflow();
        test_mthi_mtlo();
        test_div_by_zero();
        test_ignore_in_run();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
